// File: rtl/fazyrv_rf_seq.sv
// Shift sequencer for the chunk-serial register file: one start yields N = 32/CHUNKSIZE
// shift strobes, gates rd writes per chunk and reports chunk position and completion.
module fazyrv_rf_seq #(
  parameter  int CHUNKSIZE = 2,
  localparam int N         = 32 / CHUNKSIZE,
  localparam int CW        = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic          start_i,
  input  logic          wb_i,
  input  logic [4:0]    rd_i,
  input  logic          stall_i,
  input  logic          abort_i,
  output logic          shft_o,
  output logic          we_o,
  output logic [CW-1:0] cnt_o,
  output logic          lsb_o,
  output logic          msb_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_q, wb_d;
  logic [4:0]    rd_q, rd_d;
  logic          done_q, done_d;
  logic          abt_q, abt_d;
  logic          shft;

  assign busy_o    = (state_q != IDLE);
  assign shft      = busy_o & ~stall_i;
  assign shft_o    = shft;
  // The rd_q check is redundant with wb_q but keeps x0 writes impossible by construction.
  assign we_o      = (state_q == RUN) & wb_q & (|rd_q) & shft & ~abort_i;
  assign cnt_o     = cnt_q;
  assign lsb_o     = busy_o & (cnt_q == '0);
  assign msb_o     = busy_o & (cnt_q == LAST);
  assign done_o    = done_q;
  assign aborted_o = abt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    abt_d   = abt_q;

    if (state_q == IDLE) begin
      if (start_i) begin
        wb_d    = wb_i & (rd_i != 5'd0);
        rd_d    = rd_i;
        cnt_d   = '0;
        abt_d   = 1'b0;
        state_d = RUN;
      end
    end else begin
      if (state_q == RUN && abort_i) begin
        abt_d = 1'b1;
        if (cnt_q != LAST || stall_i) begin
          state_d = FLUSH;
        end
      end
      if (shft) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= 1'b0;
      rd_q    <= 5'd0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// Self-checking bench for fazyrv_rf_seq (CHUNKSIZE=2, 16 chunks) against a
// shift-counting rotation model.
module tb_fazyrv_rf_seq;

  localparam int N    = 16;
  localparam int CW   = 4;
  localparam int MAXC = 64;

  logic          clk_i = 1'b0;
  logic          rst_in;
  logic          start_i, wb_i, stall_i, abort_i;
  logic [4:0]    rd_i;
  logic          shft_o, we_o, lsb_o, msb_o, busy_o, done_o, aborted_o;
  logic [CW-1:0] cnt_o;

  int total = 0;
  int bad   = 0;

  logic       stStart[MAXC];
  logic       stWb[MAXC];
  logic [4:0] stRd[MAXC];
  logic       stStall[MAXC];
  logic       stAbort[MAXC];

  logic [CW-1:0] obsCnt[MAXC];
  int lastShifts, lastWe, lastDoneCyc;
  logic lastAbtAtDone;

  // Reference: a rotation is just "16 non-stalled cycles"; writes stop at the first abort.
  bit mActive, mWb, mAbortSeen, mAbt, mDone;
  int mShifts;

  fazyrv_rf_seq #(.CHUNKSIZE(2)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .start_i(start_i), .wb_i(wb_i), .rd_i(rd_i),
    .stall_i(stall_i), .abort_i(abort_i), .shft_o(shft_o), .we_o(we_o),
    .cnt_o(cnt_o), .lsb_o(lsb_o), .msb_o(msb_o), .busy_o(busy_o),
    .done_o(done_o), .aborted_o(aborted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clearStim();
    for (int c = 0; c < MAXC; c++) begin
      stStart[c] = 1'b0; stWb[c] = 1'b0; stRd[c] = 5'd0;
      stStall[c] = 1'b0; stAbort[c] = 1'b0;
    end
  endtask

  task automatic modelReset();
    mActive = 0; mWb = 0; mAbortSeen = 0; mAbt = 0; mDone = 0; mShifts = 0;
  endtask

  task automatic runScenario(input string name, input int len);
    logic [6+CW:0] obs, exp;
    bit eShft;
    lastShifts = 0; lastWe = 0; lastDoneCyc = -1; lastAbtAtDone = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(posedge clk_i); #1;
      start_i = stStart[c]; wb_i = stWb[c]; rd_i = stRd[c];
      stall_i = stStall[c]; abort_i = stAbort[c];
      #3;
      eShft = mActive && !stStall[c];
      exp = {mActive, eShft, eShft && mWb && !mAbortSeen && !stAbort[c],
             mActive && mShifts == 0, mActive && mShifts == N-1, mDone, mAbt,
             CW'(mActive ? mShifts : 0)};
      obs = {busy_o, shft_o, we_o, lsb_o, msb_o, done_o, aborted_o, cnt_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL %s c=%0d {busy,shft,we,lsb,msb,done,abt,cnt} got=%b exp=%b",
                 name, c, obs, exp);
      end
      obsCnt[c] = cnt_o;
      if (shft_o === 1'b1) lastShifts++;
      if (we_o === 1'b1) lastWe++;
      if (done_o === 1'b1 && c > 0 && lastDoneCyc < 0) begin
        lastDoneCyc   = c;
        lastAbtAtDone = aborted_o;
      end
      mDone = 0;
      if (!mActive) begin
        if (stStart[c]) begin
          mActive = 1; mShifts = 0; mAbortSeen = 0; mAbt = 0;
          mWb = stWb[c] && (stRd[c] != 5'd0);
        end
      end else begin
        if (stAbort[c] && !mAbortSeen) begin
          mAbortSeen = 1; mAbt = 1;
        end
        if (eShft) begin
          mShifts++;
          if (mShifts == N) begin
            mActive = 0; mShifts = 0; mDone = 1;
          end
        end
      end
    end
    clearStim();
  endtask

  task automatic test_reset();
    total++;
    if ({shft_o, we_o, cnt_o, lsb_o, msb_o, busy_o, done_o, aborted_o} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_values got=%b exp=0",
               {shft_o, we_o, cnt_o, lsb_o, msb_o, busy_o, done_o, aborted_o});
    end
  endtask

  task automatic test_basic_write();
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd5;
    runScenario("basic", 20);
    total++;
    if (lastShifts != 16 || lastWe != 16 || lastDoneCyc != 17 || lastAbtAtDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_summary shifts=%0d we=%0d done@%0d abt=%b exp 16/16/17/0",
               lastShifts, lastWe, lastDoneCyc, lastAbtAtDone);
    end
  endtask

  task automatic test_x0();
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd0;
    runScenario("x0", 20);
    total++;
    if (lastShifts != 16 || lastWe != 0 || lastDoneCyc != 17) begin
      bad++;
      $display("[TB] FAIL x0_summary shifts=%0d we=%0d done@%0d exp 16/0/17",
               lastShifts, lastWe, lastDoneCyc);
    end
  endtask

  task automatic test_stall();
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd7;
    stStall[3] = 1; stStall[4] = 1;
    runScenario("stall", 22);
    total++;
    if (lastShifts != 16 || lastDoneCyc != 19 || obsCnt[3] !== 4'd2 || obsCnt[4] !== 4'd2) begin
      bad++;
      $display("[TB] FAIL stall_summary shifts=%0d done@%0d cnt3=%0d cnt4=%0d exp 16/19/2/2",
               lastShifts, lastDoneCyc, obsCnt[3], obsCnt[4]);
    end
  endtask

  task automatic test_abort_mid();
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd3;
    stAbort[7] = 1;
    runScenario("abort_mid", 20);
    total++;
    if (lastShifts != 16 || lastWe != 6 || lastDoneCyc != 17 || lastAbtAtDone !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_mid_summary shifts=%0d we=%0d done@%0d abt=%b exp 16/6/17/1",
               lastShifts, lastWe, lastDoneCyc, lastAbtAtDone);
    end
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd4;
    runScenario("abort_clear", 20);
    total++;
    if (aborted_o !== 1'b0 || lastWe != 16) begin
      bad++;
      $display("[TB] FAIL abort_clear aborted=%b we=%0d exp 0/16", aborted_o, lastWe);
    end
  endtask

  task automatic test_abort_last();
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd31;
    stAbort[16] = 1;
    runScenario("abort_last", 20);
    total++;
    if (lastShifts != 16 || lastWe != 15 || lastDoneCyc != 17 || lastAbtAtDone !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_last_summary shifts=%0d we=%0d done@%0d abt=%b exp 16/15/17/1",
               lastShifts, lastWe, lastDoneCyc, lastAbtAtDone);
    end
  endtask

  task automatic test_stall_abort();
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd12;
    stStall[5] = 1; stAbort[5] = 1;
    runScenario("stall_abort", 21);
    total++;
    if (lastShifts != 16 || lastWe != 4 || lastDoneCyc != 18 || lastAbtAtDone !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_abort_summary shifts=%0d we=%0d done@%0d abt=%b exp 16/4/18/1",
               lastShifts, lastWe, lastDoneCyc, lastAbtAtDone);
    end
  endtask

  task automatic test_back_to_back();
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd9;
    stStart[17] = 1; stWb[17] = 1; stRd[17] = 5'd10;
    runScenario("back_to_back", 37);
    total++;
    if (lastShifts != 32 || lastWe != 32 || lastDoneCyc != 17) begin
      bad++;
      $display("[TB] FAIL b2b_summary shifts=%0d we=%0d done@%0d exp 32/32/17",
               lastShifts, lastWe, lastDoneCyc);
    end
  endtask

  task automatic test_reset_mid();
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd6;
    runScenario("pre_reset", 10);
    @(posedge clk_i); #1;
    total++;
    if (cnt_o !== 4'd9 || busy_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset_cnt cnt=%0d busy=%b exp 9/1", cnt_o, busy_o);
    end
    #1 rst_in = 1'b0;
    #1;
    test_reset();
    modelReset();
    repeat (2) @(posedge clk_i);
    #1 rst_in = 1'b1;
    stStart[0] = 1; stWb[0] = 1; stRd[0] = 5'd6;
    stStart[5] = 1; stWb[5] = 1; stRd[5] = 5'd1;
    runScenario("post_reset", 20);
    total++;
    if (lastShifts != 16 || lastDoneCyc != 17) begin
      bad++;
      $display("[TB] FAIL post_reset_summary shifts=%0d done@%0d exp 16/17",
               lastShifts, lastDoneCyc);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      stStart[0] = 1;
      stWb[0]    = 1'($urandom_range(0, 1));
      stRd[0]    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      for (int c = 1; c <= 25; c++) stStall[c] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) stAbort[$urandom_range(1, 20)] = 1;
      if ($urandom_range(0, 1) == 1) begin
        int d;
        d = $urandom_range(2, 15);
        stStart[d] = 1; stWb[d] = 1; stRd[d] = 5'd17;
      end
      runScenario("random", 48);
      total++;
      if (lastShifts != 16) begin
        bad++;
        $display("[TB] FAIL random_shifts run=%0d got=%0d exp=16", r, lastShifts);
      end
    end
  endtask

  initial begin
    rst_in = 1'b0;
    start_i = 0; wb_i = 0; rd_i = 5'd0; stall_i = 0; abort_i = 0;
    clearStim();
    modelReset();
    #1;
    test_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_in = 1'b1;
    test_basic_write();
    test_x0();
    test_stall();
    test_abort_mid();
    test_abort_last();
    test_stall_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
